vga_scanout: RTL and testbench

- Display-side reader of the double-buffered 640x480 RGB333 framebuffer that the drawing blocks fill pixel by pixel.
- Generates 640x480@60 VGA timing and issues linear read addresses (y*640 + x) into the front buffer.
- Outputs registered pixel data with hsync, vsync and de aligned to it.
- Watches the drawing side's swap toggle and flips front/back buffers only at vertical blanking, so a frame never tears.

---
 rtl/vga_scanout.sv | 93 +++++++++
 tb/tb_vga_scanout.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing and front-buffer reader with tear-free buffer swap at vblank
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swap,
  output logic        rd_en,
  output logic        rd_buf,
  output logic [18:0] rd_addr,
  input  logic [8:0]  rd_data,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [2:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D = READ_LATENCY + 1;
  logic [9:0] hcnt, vcnt;
  logic active, hs_n, vs_n, last_h, flip_pt, swap_edge;
  logic front_buf, pending, swap_q, fs;
  logic [D-1:0] act_d, hs_d, vs_d;
  logic [8:0] rgb;
  always_comb begin
    last_h = hcnt == 10'(H_TOTAL - 1);
    active = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
    hs_n = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
    vs_n = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
    flip_pt = last_h && (vcnt == 10'(V_ACTIVE - 1));
    swap_edge = swap ^ swap_q;
    rd_en = active && !rst;
    rd_addr = rd_en ? 19'(vcnt) * 19'(H_ACTIVE) + 19'(hcnt) : '0;
    rd_buf = front_buf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= last_h ? '0 : hcnt + 10'd1;
      if (last_h) vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
    end
  end
  // rd_data for the pixel addressed at t arrives while act_d[READ_LATENCY-1] carries active(t)
  always_ff @(posedge clk) begin
    if (rst) begin
      act_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
      rgb <= '0;
      fs <= 1'b0;
    end else begin
      act_d <= {act_d[D-2:0], active};
      hs_d <= {hs_d[D-2:0], hs_n};
      vs_d <= {vs_d[D-2:0], vs_n};
      rgb <= act_d[READ_LATENCY-1] ? rd_data : '0;
      fs <= (hcnt == '0) && (vcnt == '0);
    end
  end
  // requests collapse into one flip, applied only on the last clock before vblank
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_q <= 1'b0;
      front_buf <= 1'b0;
      pending <= 1'b0;
    end else begin
      swap_q <= swap;
      if (flip_pt && (pending || swap_edge)) begin
        front_buf <= ~front_buf;
        pending <= 1'b0;
      end else if (swap_edge) pending <= 1'b1;
    end
  end
  assign vga_r = rgb[8:6];
  assign vga_g = rgb[5:3];
  assign vga_b = rgb[2:0];
  assign de = act_d[D-1];
  assign hsync = hs_d[D-1];
  assign vsync = vs_d[D-1];
  assign frame_start = fs;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout; a/b use full 640x480 timing (latency 1 and 3), c uses a small frame (latency 2)
module tb_vga_scanout;
  logic clk = 0, rst = 1, swap = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  typedef struct packed {logic de; logic hs; logic vs; logic [8:0] rgb;} out_t;
  logic a_en, a_buf, a_hs, a_vs, a_de, a_fs, b_en, b_buf, b_hs, b_vs, b_de, b_fs, c_en, c_buf, c_hs, c_vs, c_de, c_fs;
  logic [18:0] a_addr, b_addr, c_addr, a_p, b_p0, b_p1, b_p2, c_p0, c_p1;
  logic [8:0] a_data, b_data, c_data;
  logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  always @(posedge clk) begin
    a_p <= a_addr;
    b_p0 <= b_addr; b_p1 <= b_p0; b_p2 <= b_p1;
    c_p0 <= c_addr; c_p1 <= c_p0;
  end
  assign a_data = a_p[8:0];
  assign b_data = b_p2[8:0];
  assign c_data = c_p1[8:0];
  vga_scanout #(.READ_LATENCY(1)) u_a (.clk(clk), .rst(rst), .swap(swap), .rd_en(a_en), .rd_buf(a_buf),
    .rd_addr(a_addr), .rd_data(a_data), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .frame_start(a_fs));
  vga_scanout #(.READ_LATENCY(3)) u_b (.clk(clk), .rst(rst), .swap(swap), .rd_en(b_en), .rd_buf(b_buf),
    .rd_addr(b_addr), .rd_data(b_data), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hsync(b_hs), .vsync(b_vs),
    .de(b_de), .frame_start(b_fs));
  vga_scanout #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .READ_LATENCY(2)) u_c (.clk(clk), .rst(rst), .swap(swap), .rd_en(c_en), .rd_buf(c_buf),
    .rd_addr(c_addr), .rd_data(c_data), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .hsync(c_hs), .vsync(c_vs),
    .de(c_de), .frame_start(c_fs));
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset(input logic s);
    rst = 1;
    swap = s;
    repeat (5) step;
    rst = 0;
    #1;
  endtask
  task automatic test_reset;
    rst = 1;
    swap = 1;
    repeat (5) step;
    checks++;
    if ({a_r, a_g, a_b, a_de, a_hs, a_vs} !== 12'b000000000_011) begin
      failures++;
      $display("FAIL reset_video: got rgb=%h de=%b hs=%b vs=%b expected 0 0 1 1", {a_r, a_g, a_b}, a_de, a_hs, a_vs);
    end
    checks++;
    if ({a_en, a_addr, a_buf, a_fs} !== 22'd0) begin
      failures++;
      $display("FAIL reset_read: got en=%b addr=%0d buf=%b fs=%b expected all 0", a_en, a_addr, a_buf, a_fs);
    end
    checks++;
    if ({c_de, c_hs, c_vs, c_en, c_buf} !== 5'b01100) begin
      failures++;
      $display("FAIL reset_small: got de=%b hs=%b vs=%b en=%b buf=%b expected 0 1 1 0 0", c_de, c_hs, c_vs, c_en, c_buf);
    end
    rst = 0;
    #1;
    checks++;
    if ({a_en, a_addr, a_fs} !== {1'b1, 19'd0, 1'b0}) begin
      failures++;
      $display("FAIL first_cycle: got en=%b addr=%0d fs=%b expected 1 0 0", a_en, a_addr, a_fs);
    end
    step;
    checks++;
    if (a_fs !== 1'b1) begin
      failures++;
      $display("FAIL frame_start_after_reset: got %b expected 1", a_fs);
    end
    repeat (1598) step;
    checks++;
    if (c_buf !== 1'b0) begin
      failures++;
      $display("FAIL held_swap_before_flip: got %b expected 0", c_buf);
    end
    step;
    checks++;
    if (c_buf !== 1'b1) begin
      failures++;
      $display("FAIL held_swap_flip: got %b expected 1", c_buf);
    end
  endtask
  task automatic test_line_latency;
    out_t qa[$], qb[$];
    out_t e;
    bit fr = 0, fa = 0, fb = 0;
    int hs_low = 0, hs_first = -1, hs_second = -1, de_cnt = 0, b_rise = -1;
    logic prev_hs = 1, prev_bde = 0;
    do_reset(0);
    for (int i = 0; i < 1610; i++) begin
      int h, v, addr;
      logic act, hsn;
      h = i % 800;
      v = i / 800;
      act = h < 640;
      hsn = !(h >= 656 && h < 752);
      addr = act ? v * 640 + h : 0;
      if (!fr) begin
        checks++;
        if ({a_en, a_addr} !== {act, 19'(addr)}) begin
          failures++; fr = 1;
          $display("FAIL read_addr@%0d: got en=%b addr=%0d expected en=%b addr=%0d", i, a_en, a_addr, act, addr);
        end
      end
      qa.push_back('{act, hsn, 1'b1, act ? 9'(addr) : 9'd0});
      qb.push_back('{act, hsn, 1'b1, act ? 9'(addr) : 9'd0});
      if (qa.size() == 3) begin
        e = qa.pop_front();
        if (!fa) begin
          checks++;
          if ({a_de, a_hs, a_vs, a_r, a_g, a_b} !== e) begin
            failures++; fa = 1;
            $display("FAIL pipe_lat1@%0d: got %h expected %h", i, {a_de, a_hs, a_vs, a_r, a_g, a_b}, e);
          end
        end
      end
      if (qb.size() == 5) begin
        e = qb.pop_front();
        if (!fb) begin
          checks++;
          if ({b_de, b_hs, b_vs, b_r, b_g, b_b} !== e) begin
            failures++; fb = 1;
            $display("FAIL pipe_lat3@%0d: got %h expected %h", i, {b_de, b_hs, b_vs, b_r, b_g, b_b}, e);
          end
        end
      end
      if (prev_hs && !a_hs) begin
        if (hs_first < 0) hs_first = i;
        else if (hs_second < 0) hs_second = i;
      end
      prev_hs = a_hs;
      if (!a_hs) hs_low++;
      if (i < 1600 && a_de) de_cnt++;
      if (b_de && !prev_bde && b_rise < 0) b_rise = i;
      prev_bde = b_de;
      if (i == 1605) begin
        checks++;
        if (a_addr !== 19'd1285) begin
          failures++;
          $display("FAIL addr_5_2: got %0d expected 1285", a_addr);
        end
      end
      if (i == 1607) begin
        checks++;
        if ({a_de, a_r, a_g, a_b} !== {1'b1, 9'd261}) begin
          failures++;
          $display("FAIL pixel_5_2_lat1: got de=%b rgb=%0d expected 1 261", a_de, {a_r, a_g, a_b});
        end
      end
      if (i == 1609) begin
        checks++;
        if ({b_de, b_r, b_g, b_b} !== {1'b1, 9'd261}) begin
          failures++;
          $display("FAIL pixel_5_2_lat3: got de=%b rgb=%0d expected 1 261", b_de, {b_r, b_g, b_b});
        end
      end
      step;
    end
    checks++;
    if (hs_first !== 658 || hs_second - hs_first !== 800) begin
      failures++;
      $display("FAIL hsync_position: got start=%0d period=%0d expected 658 800", hs_first, hs_second - hs_first);
    end
    checks++;
    if (hs_low !== 192) begin
      failures++;
      $display("FAIL hsync_width: got %0d low clocks expected 192", hs_low);
    end
    checks++;
    if (de_cnt !== 1280) begin
      failures++;
      $display("FAIL de_count: got %0d expected 1280", de_cnt);
    end
    checks++;
    if (b_rise !== 4) begin
      failures++;
      $display("FAIL de_rise_lat3: got %0d expected 4", b_rise);
    end
  endtask
  task automatic test_frame;
    int vs_low = 0, vs_first = -1, fs_first = -1, fs_second = -1, de_cnt = 0;
    logic prev_vs = 1;
    do_reset(0);
    for (int i = 0; i < 2165; i++) begin
      if (prev_vs && !c_vs && vs_first < 0) vs_first = i;
      prev_vs = c_vs;
      if (!c_vs) vs_low++;
      if (c_fs) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (i < 2160 && c_de) de_cnt++;
      if (i == 1583) begin
        checks++;
        if ({c_en, c_addr} !== {1'b1, 19'd1279}) begin
          failures++;
          $display("FAIL last_addr: got en=%b addr=%0d expected 1 1279", c_en, c_addr);
        end
      end
      if (i == 1584) begin
        checks++;
        if ({c_en, c_addr} !== 20'd0) begin
          failures++;
          $display("FAIL blank_addr: got en=%b addr=%0d expected 0 0", c_en, c_addr);
        end
      end
      if (i == 1586) begin
        checks++;
        if ({c_de, c_r, c_g, c_b} !== {1'b1, 9'd255}) begin
          failures++;
          $display("FAIL last_pixel_lat2: got de=%b rgb=%0d expected 1 255", c_de, {c_r, c_g, c_b});
        end
      end
      step;
    end
    checks++;
    if (vs_first !== 1763 || vs_low !== 160) begin
      failures++;
      $display("FAIL vsync: got start=%0d low=%0d expected 1763 160", vs_first, vs_low);
    end
    checks++;
    if (fs_first !== 1 || fs_second - fs_first !== 2160) begin
      failures++;
      $display("FAIL frame_start_period: got first=%0d period=%0d expected 1 2160", fs_first, fs_second - fs_first);
    end
    checks++;
    if (de_cnt !== 1280) begin
      failures++;
      $display("FAIL frame_de_count: got %0d expected 1280", de_cnt);
    end
  endtask
  task automatic test_swap;
    logic q[$];
    logic e;
    bit f = 0;
    do_reset(0);
    for (int i = 0; i < 5930; i++) begin
      q.push_back(i < 1600 ? 1'b0 : i < 3760 ? 1'b1 : i < 5920 ? 1'b0 : 1'b1);
      e = q.pop_front();
      if (!f) begin
        checks++;
        if (c_buf !== e) begin
          failures++; f = 1;
          $display("FAIL swap_buf@%0d: got %b expected %b", i, c_buf, e);
        end
      end
      if (i == 410 || i == 2560 || i == 2660 || i == 5919) swap = ~swap;
      step;
    end
  endtask
  task automatic test_mid_reset;
    bit f = 0;
    do_reset(0);
    for (int i = 0; i < 830; i++) begin
      if (i == 100) swap = 1;
      step;
    end
    rst = 1;
    swap = 0;
    step;
    checks++;
    if ({c_de, c_buf, c_en} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_held: got de=%b buf=%b en=%b expected 0 0 0", c_de, c_buf, c_en);
    end
    rst = 0;
    #1;
    checks++;
    if ({c_en, c_addr, c_de, c_buf} !== {1'b1, 19'd0, 2'b00}) begin
      failures++;
      $display("FAIL mid_reset_restart: got en=%b addr=%0d de=%b buf=%b expected 1 0 0 0", c_en, c_addr, c_de, c_buf);
    end
    for (int i = 0; i < 1700; i++) begin
      if (!f) begin
        checks++;
        if (c_buf !== 1'b0) begin
          failures++; f = 1;
          $display("FAIL mid_reset_no_flip@%0d: got %b expected 0", i, c_buf);
        end
      end
      step;
    end
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_line_latency;
    test_frame;
    test_swap;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
